// File: rtl/instr_fetch_unit.sv
// Instruction fetch: sequential PC generation, credit-limited memory requests,
// in-order response buffering and a valid/ready hand-off to decode with redirect flush.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm,
  output logic              rsp_err
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = 16;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_ifq [DEPTH];
  logic [PW-1:0]     r_ifq_rd;
  logic [PW-1:0]     r_ifq_wr;
  logic [CW-1:0]     r_outstanding;
  logic [DW-1:0]     r_drop_cnt;
  logic [31:0]       r_buf_data [DEPTH];
  logic [ADDR_W-1:0] r_buf_pc [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_rsp_err;

  logic [CW:0] w_credit;
  logic        w_req_fire;
  logic        w_rsp_drop;
  logic        w_rsp_take;
  logic        w_rsp_orphan;
  logic        w_rsp_retire;
  logic        w_pop;

  // Credits cover both buffered and in-flight (non-dropped) entries, so the buffer cannot overflow.
  assign w_credit       = {1'b0, r_outstanding} + {1'b0, r_count};
  assign imem_req_valid = rst_n & ~redirect_valid & (w_credit < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  assign w_rsp_drop   = imem_rsp_valid & (r_drop_cnt != '0);
  assign w_rsp_take   = imem_rsp_valid & (r_drop_cnt == '0) & (r_outstanding != '0) & ~redirect_valid;
  assign w_rsp_orphan = imem_rsp_valid & (r_drop_cnt == '0) & (r_outstanding == '0);
  // A response that retires a known request (dropped or live) during a redirect is not re-counted.
  assign w_rsp_retire = imem_rsp_valid & ((r_drop_cnt != '0) | (r_outstanding != '0));

  assign dec_valid = (r_count != '0);
  assign w_pop     = dec_valid & dec_ready & ~redirect_valid;

  assign instr    = r_buf_data[r_head];
  assign instr_pc = r_buf_pc[r_head];
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign rsp_err  = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_ifq_rd      <= '0;
      r_ifq_wr      <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_rsp_err     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_ifq[i]      <= '0;
        r_buf_data[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else begin
      if (w_rsp_orphan) begin
        r_rsp_err <= 1'b1;
      end
      if (redirect_valid) begin
        r_pc          <= redirect_pc;
        r_ifq_rd      <= '0;
        r_ifq_wr      <= '0;
        r_outstanding <= '0;
        r_drop_cnt    <= r_drop_cnt + DW'(r_outstanding) - DW'(w_rsp_retire);
        r_head        <= '0;
        r_tail        <= '0;
        r_count       <= '0;
      end else begin
        if (w_req_fire) begin
          r_ifq[r_ifq_wr] <= r_pc;
          r_ifq_wr        <= r_ifq_wr + PW'(1);
          r_pc            <= r_pc + ADDR_W'(4);
        end
        if (w_rsp_drop) begin
          r_drop_cnt <= r_drop_cnt - DW'(1);
        end
        if (w_rsp_take) begin
          r_buf_data[r_tail] <= imem_rsp_data;
          r_buf_pc[r_tail]   <= r_ifq[r_ifq_rd];
          r_tail             <= r_tail + PW'(1);
          r_ifq_rd           <= r_ifq_rd + PW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + PW'(1);
        end
        r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);
        r_count       <= r_count + CW'(w_rsp_take) - CW'(w_pop);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_rsp_take && !w_pop && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model with programmable response
// gating, expected instructions queued at request accept and compared at decode.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req_valid;
  logic              imem_req_ready = 1'b0;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid = 1'b0;
  logic [31:0]       imem_rsp_data = '0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              dec_valid;
  logic              dec_ready = 1'b0;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic              rsp_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0),
    .DEPTH    (DEPTH)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .shamt          (shamt),
    .funct          (funct),
    .imm            (imm),
    .rsp_err        (rsp_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          avail;
  } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          rcv_cnt = 0;
  bit          err_model = 1'b0;
  bit          do_release = 1'b0;
  bit          cfg_dec_ready = 1'b1;
  bit          cfg_req_ready = 1'b1;
  bit          cfg_mem_en = 1'b1;
  logic [31:0] model_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0010: return 32'h20A8_FFFF;
      32'h0000_0014: return 32'h012A_4020;
      default:       return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp_v, cyc);
    end
  endtask

  // One clock of stimulus: observe state at the negedge, drive inputs, then update the model
  // with what the coming rising edge will do.
  task automatic tick(input bit do_redir = 1'b0, input logic [31:0] tgt = '0, input bit inject = 1'b0);
    exp_t  h;
    mreq_t m;
    bit    model_dec_v;
    bit    model_req_v;
    @(negedge clk);
    cyc++;
    model_dec_v = (rcv_cnt > 0);
    check_eq("dec_valid", dec_valid, model_dec_v);
    check_eq("rsp_err", rsp_err, err_model);
    if (model_dec_v) begin
      h = exp_q[0];
      check_eq("instr_pc", instr_pc, h.pc);
      check_eq("instr", instr, h.data);
      check_eq("opcode", opcode, h.data[31:26]);
      check_eq("rs", rs, h.data[25:21]);
      check_eq("rt", rt, h.data[20:16]);
      check_eq("rd", rd, h.data[15:11]);
      check_eq("shamt", shamt, h.data[10:6]);
      check_eq("funct", funct, h.data[5:0]);
      check_eq("imm", imm, h.data[15:0]);
      if (h.pc == 32'h10) begin
        check_eq("addi_opcode", opcode, 6'h08);
        check_eq("addi_rs", rs, 5'd5);
        check_eq("addi_rt", rt, 5'd8);
        check_eq("addi_imm", imm, 16'hFFFF);
      end
      if (h.pc == 32'h14) begin
        check_eq("add_opcode", opcode, 6'h00);
        check_eq("add_rs", rs, 5'd9);
        check_eq("add_rt", rt, 5'd10);
        check_eq("add_rd", rd, 5'd8);
        check_eq("add_shamt", shamt, 5'd0);
        check_eq("add_funct", funct, 6'h20);
      end
    end
    if (do_release) begin
      rst_n      = 1'b1;
      do_release = 1'b0;
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (inject) begin
      check_eq("inject_idle", mem_q.size(), 0);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      err_model      = 1'b1;
    end else if (cfg_mem_en && mem_q.size() > 0 && mem_q[0].avail <= cyc) begin
      m = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.addr);
      if (!m.stale && !do_redir) rcv_cnt++;
    end
    redirect_valid = do_redir;
    redirect_pc    = tgt;
    dec_ready      = cfg_dec_ready;
    imem_req_ready = cfg_req_ready;
    #1;
    model_req_v = !do_redir && (exp_q.size() < DEPTH);
    check_eq("req_valid", imem_req_valid, model_req_v);
    if (do_redir) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_q.delete();
      rcv_cnt  = 0;
      model_pc = tgt;
    end else begin
      if (model_dec_v && cfg_dec_ready) begin
        void'(exp_q.pop_front());
        rcv_cnt--;
      end
      if (model_req_v && cfg_req_ready) begin
        check_eq("req_addr", imem_req_addr, model_pc);
        h.pc   = model_pc;
        h.data = mem_word(model_pc);
        exp_q.push_back(h);
        m.addr  = model_pc;
        m.stale = 1'b0;
        m.avail = cyc + 1;
        mem_q.push_back(m);
        model_pc = model_pc + 32'd4;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_dec_valid", dec_valid, 1'b0);
    check_eq("rst_req_valid", imem_req_valid, 1'b0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    check_eq("rst_req_addr", imem_req_addr, 32'h0);

    // Straight-line fetch from reset
    model_pc   = 32'h0;
    do_release = 1'b1;
    repeat (16) tick();

    // Decode stall then release
    cfg_dec_ready = 1'b0;
    repeat (10) tick();
    cfg_dec_ready = 1'b1;
    repeat (8) tick();

    // Redirect with requests in flight whose responses must be dropped
    cfg_mem_en = 1'b0;
    repeat (3) tick();
    tick(1'b1, 32'h100);
    cfg_mem_en = 1'b1;
    repeat (8) tick();

    // Address wrap
    tick(1'b1, 32'hFFFF_FFFC);
    repeat (6) tick();

    // Back-to-back redirects with held responses
    cfg_mem_en = 1'b0;
    repeat (2) tick();
    tick(1'b1, 32'h200);
    tick(1'b1, 32'h300);
    cfg_mem_en = 1'b1;
    repeat (8) tick();

    // Orphan response once everything has drained
    cfg_req_ready = 1'b0;
    repeat (4) tick();
    tick(1'b0, '0, 1'b1);
    repeat (3) tick();
    cfg_req_ready = 1'b1;

    // Randomised traffic
    repeat (400) begin
      cfg_dec_ready = ($urandom_range(0, 3) != 0);
      cfg_req_ready = ($urandom_range(0, 3) != 0);
      cfg_mem_en    = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 29) == 0) tick(1'b1, $urandom & 32'hFFFF_FFFC);
      else                            tick();
    end

    cfg_dec_ready = 1'b1;
    cfg_req_ready = 1'b0;
    cfg_mem_en    = 1'b1;
    repeat (12) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
